hazard_sequencer: RTL and testbench

//  Pipeline control for the 5-stage RISC-V core. Drives the stall/flush enables of the F/D/E/M/W

---
 rtl/hazard_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_hazard_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline control for the 5-stage RISC-V core. Produces the stall/flush
//   enables for the F/D/E/M/W pipeline registers and the E-stage forwarding
//   selects. It also runs a RUN / MEM_WAIT / HALT FSM that freezes the pipe
//   during data-memory wait states, with a wait timeout. Saturating counters
//   record stall and flush cycles.
//
// Ports
//   clk_i, reset_i            clock; asynchronous active-high reset
//   rs1_d_i, rs2_d_i          source registers of the instruction in D
//   rs1_e_i, rs2_e_i, rd_e_i  source and destination registers of the instruction in E
//   load_e_i, pc_src_e_i      E holds a load / a taken branch or jump
//   rd_m_i, reg_write_m_i     destination register and write enable in M
//   rd_w_i, reg_write_w_i     destination register and write enable in W
//   mem_req_m_i, mem_ready_i  data-memory request in M / access completes this cycle
//   stall_{f,d,e,m}_o         hold the PC and the F->D, D->E, E->M registers
//   flush_{d,e,w}_o           zero the F->D, D->E, M->W registers
//   forward_{a,b}_e_o         operand selects: 00 regfile, 01 W result, 10 M ALU result
//   halted_o, mem_timeout_o   FSM is in HALT / sticky memory-timeout flag
//   stall_cnt_o, flush_cnt_o  saturating cycle counters for stall_f and flush_d
module hazard_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rs1_e_i,
  input  logic [4:0]       rs2_e_i,
  input  logic [4:0]       rd_e_i,
  input  logic             load_e_i,
  input  logic             pc_src_e_i,
  input  logic [4:0]       rd_m_i,
  input  logic [4:0]       rd_w_i,
  input  logic             reg_write_m_i,
  input  logic             reg_write_w_i,
  input  logic             mem_req_m_i,
  input  logic             mem_ready_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             stall_m_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_w_o,
  output logic [1:0]       forward_a_e_o,
  output logic [1:0]       forward_b_e_o,
  output logic             halted_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic lw_stall, mem_stall, freeze;

  assign lw_stall  = load_e_i && (rd_e_i != 5'd0) &&
                     ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
  assign mem_stall = mem_req_m_i && !mem_ready_i;

  // In MEM_WAIT the release is zero-latency: as soon as mem_ready is seen,
  // the normal RUN outputs apply in that same cycle.
  assign freeze = (state_q == HALT) ||
                  ((state_q == MEM_WAIT) && !mem_ready_i) ||
                  ((state_q == RUN) && mem_stall);

  // Output decode. While reset is asserted, every register is bubbled
  // and nothing is held.
  always_comb begin
    stall_f_o     = 1'b0;
    stall_d_o     = 1'b0;
    stall_e_o     = 1'b0;
    stall_m_o     = 1'b0;
    flush_d_o     = 1'b0;
    flush_e_o     = 1'b0;
    flush_w_o     = 1'b0;
    forward_a_e_o = 2'b00;
    forward_b_e_o = 2'b00;
    halted_o      = 1'b0;
    if (reset_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_w_o = 1'b1;
    end else begin
      if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs1_e_i))
        forward_a_e_o = 2'b10;
      else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs1_e_i))
        forward_a_e_o = 2'b01;
      if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs2_e_i))
        forward_b_e_o = 2'b10;
      else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs2_e_i))
        forward_b_e_o = 2'b01;
      halted_o = (state_q == HALT);
      if (freeze) begin
        // flush_w stops the instruction held in M from writing W twice.
        stall_f_o = 1'b1;
        stall_d_o = 1'b1;
        stall_e_o = 1'b1;
        stall_m_o = 1'b1;
        flush_w_o = 1'b1;
      end else begin
        // A taken branch discards the instruction in D anyway, so it wins
        // over a load-use stall.
        stall_f_o = lw_stall && !pc_src_e_i;
        stall_d_o = lw_stall && !pc_src_e_i;
        flush_d_o = pc_src_e_i;
        flush_e_o = lw_stall || pc_src_e_i;
      end
    end
  end

  // Next state. wait_cnt counts frozen cycles including the RUN cycle that
  // first saw the stall, so HALT follows TIMEOUT+1 not-ready cycles.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
          state_d       = HALT;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Performance counters. They saturate instead of wrapping. HALT cycles
  // are left out of the stall count so a hang does not inflate it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f_o && (state_q != HALT) && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_d_o && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout_o = mem_timeout_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer
//   Directed scenarios for hazard_sequencer. Each scenario task drives its
//   inputs one cycle at a time and compares against hand-computed values.
module tb_hazard_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [4:0]  rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, rd_m_i, rd_w_i;
  logic        load_e_i, pc_src_e_i, reg_write_m_i, reg_write_w_i;
  logic        mem_req_m_i, mem_ready_i;
  logic        stall_f_o, stall_d_o, stall_e_o, stall_m_o;
  logic        flush_d_o, flush_e_o, flush_w_o;
  logic [1:0]  forward_a_e_o, forward_b_e_o;
  logic        halted_o, mem_timeout_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int tests = 0;
  int fails = 0;

  hazard_sequencer #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .rs1_e_i(rs1_e_i), .rs2_e_i(rs2_e_i),
    .rd_e_i(rd_e_i), .load_e_i(load_e_i), .pc_src_e_i(pc_src_e_i),
    .rd_m_i(rd_m_i), .rd_w_i(rd_w_i),
    .reg_write_m_i(reg_write_m_i), .reg_write_w_i(reg_write_w_i),
    .mem_req_m_i(mem_req_m_i), .mem_ready_i(mem_ready_i),
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o),
    .stall_m_o(stall_m_o), .flush_d_o(flush_d_o), .flush_e_o(flush_e_o),
    .flush_w_o(flush_w_o), .forward_a_e_o(forward_a_e_o),
    .forward_b_e_o(forward_b_e_o), .halted_o(halted_o),
    .mem_timeout_o(mem_timeout_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to 1 ns after the next rising edge; inputs change and
  // outputs are sampled there, well away from the clock edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d_i = 5'd0; rs2_d_i = 5'd0; rs1_e_i = 5'd0; rs2_e_i = 5'd0;
    rd_e_i = 5'd0; rd_m_i = 5'd0; rd_w_i = 5'd0;
    load_e_i = 1'b0; pc_src_e_i = 1'b0;
    reg_write_m_i = 1'b0; reg_write_w_i = 1'b0;
    mem_req_m_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  // Outputs while reset is asserted, with a forwarding match applied
  // that must be masked.
  task automatic test_reset();
    clear_inputs();
    reset_i = 1'b1;
    reg_write_m_i = 1'b1; rd_m_i = 5'd3; rs1_e_i = 5'd3;
    load_e_i = 1'b1; rd_e_i = 5'd5; rs1_d_i = 5'd5;
    #1;
    tests++;
    if ({stall_f_o, stall_d_o, stall_e_o, stall_m_o} !== 4'b0000) begin
      fails++; $display("[TB] FAIL reset_stalls got %b exp 0000", {stall_f_o, stall_d_o, stall_e_o, stall_m_o});
    end
    tests++;
    if ({flush_d_o, flush_e_o, flush_w_o} !== 3'b111) begin
      fails++; $display("[TB] FAIL reset_flushes got %b exp 111", {flush_d_o, flush_e_o, flush_w_o});
    end
    tests++;
    if (forward_a_e_o !== 2'b00 || halted_o !== 1'b0 || mem_timeout_o !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_misc fwd=%b halted=%b timeout=%b exp 00/0/0", forward_a_e_o, halted_o, mem_timeout_o);
    end
    step(); step();
    tests++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_counters stall=%0d flush=%0d exp 0/0", stall_cnt_o, flush_cnt_o);
    end
    reset_i = 1'b0;
    clear_inputs();
    step();
  endtask

  // Load-use hazard: one cycle of stall_f/stall_d plus bubble into E.
  task automatic test_load_use();
    load_e_i = 1'b1; rd_e_i = 5'd5; rs1_d_i = 5'd5;
    #1;
    tests++;
    if ({stall_f_o, stall_d_o, flush_e_o, flush_d_o, stall_e_o} !== 5'b11100) begin
      fails++; $display("[TB] FAIL load_use_outputs got %b exp 11100", {stall_f_o, stall_d_o, flush_e_o, flush_d_o, stall_e_o});
    end
    step();
    clear_inputs();
    #1;
    tests++;
    if (stall_f_o !== 1'b0 || stall_cnt_o !== 32'd1 || flush_cnt_o !== 32'd0) begin
      fails++; $display("[TB] FAIL load_use_count stall_f=%b stall_cnt=%0d flush_cnt=%0d exp 0/1/0", stall_f_o, stall_cnt_o, flush_cnt_o);
    end
    // x0 as a load destination never creates a hazard
    load_e_i = 1'b1; rd_e_i = 5'd0; rs2_d_i = 5'd0;
    #1;
    tests++;
    if (stall_f_o !== 1'b0 || flush_e_o !== 1'b0) begin
      fails++; $display("[TB] FAIL load_x0 stall_f=%b flush_e=%b exp 0/0", stall_f_o, flush_e_o);
    end
    step();
    clear_inputs();
  endtask

  // Taken branch together with a load-use hazard: the branch wins.
  task automatic test_branch_override();
    load_e_i = 1'b1; rd_e_i = 5'd5; rs1_d_i = 5'd5; pc_src_e_i = 1'b1;
    #1;
    tests++;
    if ({flush_d_o, flush_e_o, stall_f_o, stall_d_o} !== 4'b1100) begin
      fails++; $display("[TB] FAIL branch_override got %b exp 1100", {flush_d_o, flush_e_o, stall_f_o, stall_d_o});
    end
    step();
    clear_inputs();
    #1;
    tests++;
    if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd1) begin
      fails++; $display("[TB] FAIL branch_count flush_cnt=%0d stall_cnt=%0d exp 1/1", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_forwarding();
    reg_write_m_i = 1'b1; rd_m_i = 5'd3; reg_write_w_i = 1'b1; rd_w_i = 5'd3;
    rs1_e_i = 5'd3; rs2_e_i = 5'd3;
    #1;
    tests++;
    if (forward_a_e_o !== 2'b10 || forward_b_e_o !== 2'b10) begin
      fails++; $display("[TB] FAIL fwd_m_priority a=%b b=%b exp 10/10", forward_a_e_o, forward_b_e_o);
    end
    rd_m_i = 5'd0; rs2_e_i = 5'd4;
    #1;
    tests++;
    if (forward_a_e_o !== 2'b01 || forward_b_e_o !== 2'b00) begin
      fails++; $display("[TB] FAIL fwd_w a=%b b=%b exp 01/00", forward_a_e_o, forward_b_e_o);
    end
    rd_m_i = 5'd4;
    #1;
    tests++;
    if (forward_a_e_o !== 2'b01 || forward_b_e_o !== 2'b10) begin
      fails++; $display("[TB] FAIL fwd_mixed a=%b b=%b exp 01/10", forward_a_e_o, forward_b_e_o);
    end
    reg_write_w_i = 1'b0; reg_write_m_i = 1'b0;
    #1;
    tests++;
    if (forward_a_e_o !== 2'b00 || forward_b_e_o !== 2'b00) begin
      fails++; $display("[TB] FAIL fwd_no_write a=%b b=%b exp 00/00", forward_a_e_o, forward_b_e_o);
    end
    clear_inputs();
    step();
  endtask

  // Three not-ready cycles, then release. A pending branch and load-use
  // hazard must not flush during the wait but act on the release cycle.
  task automatic test_mem_wait();
    mem_req_m_i = 1'b1; mem_ready_i = 1'b0; pc_src_e_i = 1'b1;
    load_e_i = 1'b1; rd_e_i = 5'd7; rs2_d_i = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({stall_f_o, stall_d_o, stall_e_o, stall_m_o, flush_w_o, flush_d_o, flush_e_o} !== 7'b1111100) begin
        fails++; $display("[TB] FAIL mem_wait_cycle%0d got %b exp 1111100", i, {stall_f_o, stall_d_o, stall_e_o, stall_m_o, flush_w_o, flush_d_o, flush_e_o});
      end
      step();
    end
    mem_ready_i = 1'b1;
    #1;
    tests++;
    if ({stall_f_o, stall_e_o, stall_m_o, flush_w_o, flush_d_o, flush_e_o} !== 6'b000011) begin
      fails++; $display("[TB] FAIL mem_release got %b exp 000011", {stall_f_o, stall_e_o, stall_m_o, flush_w_o, flush_d_o, flush_e_o});
    end
    step();
    clear_inputs();
    #1;
    tests++;
    if (stall_e_o !== 1'b0 || halted_o !== 1'b0 || stall_cnt_o !== 32'd4 || flush_cnt_o !== 32'd2) begin
      fails++; $display("[TB] FAIL mem_after stall_e=%b halted=%b stall_cnt=%0d flush_cnt=%0d exp 0/0/4/2", stall_e_o, halted_o, stall_cnt_o, flush_cnt_o);
    end
  endtask

  // TIMEOUT+1 = 17 not-ready cycles lead to HALT; only reset leaves it.
  task automatic test_timeout();
    mem_req_m_i = 1'b1; mem_ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      #1;
      tests++;
      if (stall_e_o !== 1'b1 || halted_o !== 1'b0 || mem_timeout_o !== 1'b0) begin
        fails++; $display("[TB] FAIL timeout_wait%0d stall_e=%b halted=%b timeout=%b exp 1/0/0", i, stall_e_o, halted_o, mem_timeout_o);
      end
      step();
    end
    tests++;
    if (halted_o !== 1'b1 || mem_timeout_o !== 1'b1) begin
      fails++; $display("[TB] FAIL timeout_halt halted=%b timeout=%b exp 1/1", halted_o, mem_timeout_o);
    end
    mem_ready_i = 1'b1; mem_req_m_i = 1'b0; pc_src_e_i = 1'b1;
    step(); step();
    tests++;
    if ({halted_o, stall_f_o, stall_m_o, flush_w_o, flush_d_o, flush_e_o} !== 6'b111100) begin
      fails++; $display("[TB] FAIL halt_sticky got %b exp 111100", {halted_o, stall_f_o, stall_m_o, flush_w_o, flush_d_o, flush_e_o});
    end
    tests++;
    if (stall_cnt_o !== 32'd21 || flush_cnt_o !== 32'd2) begin
      fails++; $display("[TB] FAIL halt_counts stall_cnt=%0d flush_cnt=%0d exp 21/2", stall_cnt_o, flush_cnt_o);
    end
    reset_i = 1'b1;
    #1;
    tests++;
    if (halted_o !== 1'b0 || mem_timeout_o !== 1'b0 || stall_cnt_o !== 32'd0 || stall_f_o !== 1'b0) begin
      fails++; $display("[TB] FAIL halt_reset halted=%b timeout=%b stall_cnt=%0d stall_f=%b exp 0/0/0/0", halted_o, mem_timeout_o, stall_cnt_o, stall_f_o);
    end
    step();
    reset_i = 1'b0;
    clear_inputs();
    #1;
    tests++;
    if (stall_e_o !== 1'b0 || halted_o !== 1'b0) begin
      fails++; $display("[TB] FAIL halt_exit stall_e=%b halted=%b exp 0/0", stall_e_o, halted_o);
    end
  endtask

  // Counter saturation from a forced near-maximum value, then a reset in
  // the middle of a memory wait.
  task automatic test_saturation();
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    load_e_i = 1'b1; rd_e_i = 5'd9; rs1_d_i = 5'd9;
    step();
    tests++;
    if (stall_cnt_o !== 32'hFFFF_FFFE) begin
      fails++; $display("[TB] FAIL sat_increment got %h exp fffffffe", stall_cnt_o);
    end
    step(); step(); step();
    tests++;
    if (stall_cnt_o !== 32'hFFFF_FFFF) begin
      fails++; $display("[TB] FAIL sat_hold got %h exp ffffffff", stall_cnt_o);
    end
    clear_inputs();
    mem_req_m_i = 1'b1; mem_ready_i = 1'b0;
    step(); step(); step();
    tests++;
    if (stall_e_o !== 1'b1 || stall_cnt_o !== 32'hFFFF_FFFF) begin
      fails++; $display("[TB] FAIL sat_wait stall_e=%b stall_cnt=%h exp 1/ffffffff", stall_e_o, stall_cnt_o);
    end
    reset_i = 1'b1;
    #1;
    tests++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0 || stall_e_o !== 1'b0 || flush_w_o !== 1'b1) begin
      fails++; $display("[TB] FAIL midwait_reset stall_cnt=%0d flush_cnt=%0d stall_e=%b flush_w=%b exp 0/0/0/1", stall_cnt_o, flush_cnt_o, stall_e_o, flush_w_o);
    end
    step();
    reset_i = 1'b0;
    clear_inputs();
    step();
    tests++;
    if (stall_e_o !== 1'b0 || mem_timeout_o !== 1'b0 || halted_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
      fails++; $display("[TB] FAIL midwait_after stall_e=%b timeout=%b halted=%b stall_cnt=%0d exp 0/0/0/0", stall_e_o, mem_timeout_o, halted_o, stall_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_override();
    test_forwarding();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
